// File: rtl/tpu_pkg.sv
// tpu_pkg: shared defaults, drain length and loader FSM state type
package tpu_pkg;
  localparam int DEF_BITS_AB = 8;
  localparam int DEF_DIM = 8;
  localparam int DRAIN_CYCLES = 2*DEF_DIM-1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} ldr_state_t;
endpackage

// File: rtl/b_row_bank.sv
// b_row_bank: DIM-row storage, synchronous row write, combinational row read
module b_row_bank
  import tpu_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM = DEF_DIM
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DIM)-1:0]   waddr,
  input  logic [DIM*BITS_AB-1:0]   wdata,
  input  logic [$clog2(DIM)-1:0]   raddr,
  output logic [DIM*BITS_AB-1:0]   rdata
);
  logic [DIM*BITS_AB-1:0] mem [DIM];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/b_tile_loader.sv
// b_tile_loader: ping-pong B tile buffer streaming rows, then zero rows, into the skew buffer
module b_tile_loader
  import tpu_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM = DEF_DIM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [DIM*BITS_AB-1:0]    wr_data,
  output logic                      wr_ready,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      en_out,
  output logic signed [BITS_AB-1:0] Bout [DIM-1:0]
);
  localparam int DRN = DRAIN_CYCLES + 2*(DIM-DEF_DIM);
  localparam int CW = $clog2(DRN+1);
  localparam int RW = $clog2(DIM);
  ldr_state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [RW-1:0] row_ptr;
  logic fill_bank, rd_bank, nrd, wr_acc, row_last;
  logic [1:0] full, nfull;
  logic [DIM*BITS_AB-1:0] rdata [2];
  assign wr_ready = !full[fill_bank];
  assign wr_acc = wr_valid && wr_ready;
  assign row_last = row_ptr == RW'(DIM-1);
  assign busy = state != IDLE;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    b_row_bank #(.BITS_AB(BITS_AB), .DIM(DIM)) u_bank (
      .clk(clk), .we(wr_acc && fill_bank == 1'(b)), .waddr(row_ptr), .wdata(wr_data),
      .raddr(ncnt[RW-1:0]), .rdata(rdata[b])
    );
  end
  always_comb begin
    nstate = state;
    ncnt = cnt;
    nrd = rd_bank;
    nfull = full;
    if (wr_acc && row_last) nfull[fill_bank] = 1'b1;
    case (state)
      IDLE: if (start && full[rd_bank]) begin
        nstate = STREAM;
        ncnt = '0;
      end
      STREAM: if (cnt == CW'(DIM-1)) begin
        nstate = DRAIN;
        ncnt = '0;
        nfull[rd_bank] = 1'b0;
        nrd = !rd_bank;
      end else ncnt = cnt + 1'b1;
      DRAIN: if (cnt == CW'(DRN-1)) nstate = DONE; else ncnt = cnt + 1'b1;
      default: nstate = IDLE;
    endcase
  end
  // outputs are registered from the next state so row 0 appears the cycle after start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      row_ptr <= '0;
      fill_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      en_out <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < DIM; i++) Bout[i] <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      rd_bank <= nrd;
      full <= nfull;
      en_out <= nstate == STREAM || nstate == DRAIN;
      done <= nstate == DONE;
      for (int i = 0; i < DIM; i++)
        Bout[i] <= nstate == STREAM ? $signed(rdata[rd_bank][i*BITS_AB +: BITS_AB]) : '0;
      if (wr_acc) begin
        row_ptr <= row_last ? '0 : row_ptr + 1'b1;
        fill_bank <= row_last ? !fill_bank : fill_bank;
      end
    end
  end
endmodule

// File: tb/tb_b_tile_loader.sv
// tb_b_tile_loader: tile-queue reference model plus directed, table and random stimulus
module tb_b_tile_loader;
  import tpu_pkg::*;
  localparam int B = DEF_BITS_AB, D = DEF_DIM, W = B*D, L = 3*D-1;
  logic clk = 0, rst = 1, wr_valid = 0, start = 0;
  logic [W-1:0] wr_data = '0;
  logic wr_ready, busy, done, en_out;
  logic signed [B-1:0] Bout [D-1:0];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  b_tile_loader #(.BITS_AB(B), .DIM(D)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .busy(busy), .done(done), .en_out(en_out), .Bout(Bout)
  );
  // model: k is the position within a tile's output schedule (-1 idle, 0..L-1 en, L done)
  int k = -1;
  logic [W-1:0] held[$], part[$];
  typedef struct {logic wv; logic st; logic [3:0] exp;} vec_t;
  vec_t vt[11];
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] pack_bout();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[i*B +: B] = Bout[i];
    return v;
  endfunction
  function automatic logic [W-1:0] mkrow(input int r, input bit neg);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[i*B +: B] = B'(neg ? -(r*D+i+1) : r*D+i);
    return v;
  endfunction
  task automatic model_edge();
    bit rdy;
    rdy = held.size() < 2*D;
    if (k < 0) begin
      if (start && held.size() >= D) k = 0;
    end else begin
      if (k == D-1) repeat (D) void'(held.pop_front());
      k = (k == L) ? -1 : k + 1;
    end
    if (wr_valid && rdy) begin
      part.push_back(wr_data);
      if (part.size() == D) begin
        foreach (part[i]) held.push_back(part[i]);
        part.delete();
      end
    end
  endtask
  task automatic check_cycle();
    logic [3:0] ec;
    ec = {k >= 0 && k < L, k == L, k >= 0, held.size() < 2*D};
    chk("ctrl{en,done,busy,ready}", W'({en_out, done, busy, wr_ready}), W'(ec));
    chk("bout", pack_bout(), (k >= 0 && k < D) ? held[k] : '0);
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_cycle();
  endtask
  task automatic do_reset();
    rst = 1;
    #2;
    k = -1;
    held.delete();
    part.delete();
    check_cycle();
    @(posedge clk);
    #1;
    rst = 0;
    check_cycle();
  endtask
  task automatic wr(input logic [W-1:0] d);
    wr_valid = 1;
    wr_data = d;
    tick();
    wr_valid = 0;
  endtask
  task automatic run_idle(input int maxc);
    for (int c = 0; c < maxc && k >= 0; c++) tick();
    chk("idle_reached", W'(busy), '0);
  endtask
  task automatic measure(input int n, output int en_n, output int done_at, output int rdy_at);
    en_n = 0; done_at = -1; rdy_at = -1;
    for (int c = 0; c < n; c++) begin
      if (en_out) en_n++;
      if (done && done_at < 0) done_at = c;
      if (wr_ready && rdy_at < 0) rdy_at = c;
      tick();
    end
  endtask
  initial begin
    int en_n, done_at, rdy_at, ri, fall, rise;
    bit prev;
    vt = '{'{1,0,4'b1000}, '{1,0,4'b1000}, '{1,0,4'b1000}, '{1,0,4'b1000}, '{1,0,4'b1000},
           '{0,1,4'b1000}, '{1,0,4'b1000}, '{1,0,4'b1000}, '{1,1,4'b1000},
           '{0,1,4'b1110}, '{0,0,4'b1110}};
    @(posedge clk);
    #1;
    do_reset();
    // single tile, row r element i = r*8+i
    for (int r = 0; r < D; r++) wr(mkrow(r, 0));
    start = 1; tick(); start = 0;
    measure(30, en_n, done_at, rdy_at);
    chk("en_cycles", W'(en_n), W'(L));
    chk("done_cycle", W'(done_at), W'(L));
    // reset mid-stream, then start without refill is ignored
    for (int r = 0; r < D; r++) wr(mkrow(r + 3, 0));
    start = 1; tick(); start = 0;
    tick(); tick();
    do_reset();
    start = 1; tick(); tick(); tick(); start = 0;
    chk("start_after_rst", W'({busy, en_out}), '0);
    // early start and last-write-with-start table
    ri = 0;
    foreach (vt[i]) begin
      wr_valid = vt[i].wv;
      start = vt[i].st;
      wr_data = mkrow(ri + 10, 0);
      if (vt[i].wv) ri++;
      tick();
      chk($sformatf("vec%0d", i), W'({wr_ready, busy, en_out, done}), W'(vt[i].exp));
    end
    wr_valid = 0; start = 0;
    run_idle(40);
    // backpressure: 16 writes fill both banks, 17th dropped
    for (int r = 0; r < 2*D; r++) wr(mkrow(r, 0));
    chk("ready_after16", W'(wr_ready), '0);
    wr(mkrow(99, 1));
    chk("ready_after17", W'(wr_ready), '0);
    start = 1; tick(); start = 0;
    measure(30, en_n, done_at, rdy_at);
    chk("ready_rise", W'(rdy_at), W'(D));
    start = 1; tick(); start = 0;
    run_idle(40);
    start = 1; tick(); tick(); start = 0;
    chk("no_third_tile", W'(busy), '0);
    // ping-pong: tile B (negative) written while tile A streams, start held high
    for (int r = 0; r < D; r++) wr(mkrow(r + 20, 0));
    start = 1; prev = 0; fall = -1; rise = -1; en_n = 0;
    for (int c = 0; c < 60; c++) begin
      wr_valid = c < 2*D && c % 2 == 0;
      wr_data = mkrow(c / 2, 1);
      tick();
      if (en_out) en_n++;
      if (prev && !en_out && fall < 0) fall = c;
      if (!prev && en_out && fall >= 0 && rise < 0) rise = c;
      prev = en_out;
    end
    start = 0; wr_valid = 0;
    chk("pingpong_gap", W'(rise - fall), W'(2));
    chk("pingpong_en_total", W'(en_n), W'(2*L));
    // random traffic with occasional async reset
    for (int c = 0; c < 3000; c++) begin
      wr_valid = $urandom_range(0, 2) != 0;
      start = $urandom_range(0, 5) == 0;
      wr_data = {$urandom, $urandom};
      if ($urandom_range(0, 599) == 0) do_reset(); else tick();
    end
    wr_valid = 0; start = 0;
    run_idle(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
